// File: rtl/beep_sched.sv
// beep_sched: arbitrates four beep-burst requesters and sequences beep_en/tone_sel for the winner.
// Latency: ack and beep_en rise one cycle after req is sampled in IDLE; done follows N*(ON_CYCLES+OFF_CYCLES) cycles after ack (1 cycle when N=0).
// Backpressure: req is level-held until ack and ignored outside IDLE; define BEEP_SCHED_RR_EN for round-robin, otherwise fixed priority (lowest index wins).
module beep_sched #(
    parameter int ON_CYCLES  = 5_000_000,
    parameter int OFF_CYCLES = 2_500_000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [7:0]  tone_in,
    input  logic [15:0] count_in,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic        busy,
    output logic        beep_en,
    output logic [1:0]  tone_sel
);
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int IW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Terminal counts of the interval counter. On the last beep the OFF
    // interval hands over to FIN one cycle early: the FIN cycle itself is the
    // final low cycle, so done lands exactly N*(ON+OFF) cycles after ack.
    localparam logic [IW-1:0] ON_LAST    = IW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] OFF_LAST   = IW'(OFF_CYCLES - 1);
    localparam logic [IW-1:0] OFF_PRE    = IW'((OFF_CYCLES > 1) ? (OFF_CYCLES - 2) : 0);
    localparam bit            OFF_SINGLE = (OFF_CYCLES == 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] ivl;
    logic [3:0]    beep_cnt;
    logic [1:0]    owner;
    logic          win_vld;
    logic [1:0]    win_idx;
    logic [1:0]    sel_tone;
    logic [3:0]    sel_cnt;

`ifdef BEEP_SCHED_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;

    // Round-robin pick: scan from the pointer; descending loop lets the
    // nearest requester after the pointer overwrite farther ones.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Pointer moves past the winner on every grant.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (state == S_IDLE && win_vld) begin
            rr_ptr <= win_idx + 2'd1;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                win_vld = 1'b1;
                win_idx = 2'(k);
            end
        end
    end
`endif

    assign sel_tone = tone_in[{win_idx, 1'b0} +: 2];
    assign sel_cnt  = count_in[{win_idx, 2'b00} +: 4];

    // Burst sequencer: grant, ON/OFF interval timing, completion pulse.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ivl      <= '0;
            beep_cnt <= 4'd0;
            owner    <= 2'd0;
            ack      <= 4'd0;
            done     <= 4'd0;
            busy     <= 1'b0;
            beep_en  <= 1'b0;
            tone_sel <= 2'd0;
        end else begin
            ack  <= 4'd0;
            done <= 4'd0;
            case (state)
                S_IDLE: begin
                    ivl <= '0;
                    if (win_vld) begin
                        ack      <= 4'b0001 << win_idx;
                        owner    <= win_idx;
                        tone_sel <= sel_tone;
                        beep_cnt <= sel_cnt;
                        busy     <= 1'b1;
                        if (sel_cnt == 4'd0) begin
                            state <= S_FIN;
                        end else begin
                            state   <= S_ON;
                            beep_en <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (ivl == ON_LAST) begin
                        ivl     <= '0;
                        beep_en <= 1'b0;
                        if (beep_cnt != 4'd0) begin
                            beep_cnt <= beep_cnt - 4'd1;
                        end
                        state <= (OFF_SINGLE && beep_cnt == 4'd1) ? S_FIN : S_OFF;
                    end else begin
                        ivl <= ivl + 1'b1;
                    end
                end
                S_OFF: begin
                    if (!OFF_SINGLE && beep_cnt == 4'd0 && ivl == OFF_PRE) begin
                        ivl   <= '0;
                        state <= S_FIN;
                    end else if (ivl == OFF_LAST) begin
                        ivl     <= '0;
                        state   <= S_ON;
                        beep_en <= 1'b1;
                    end else begin
                        ivl <= ivl + 1'b1;
                    end
                end
                default: begin
                    done  <= 4'b0001 << owner;
                    busy  <= 1'b0;
                    ivl   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_beep_sched.sv
// Scoreboard bench for beep_sched: driver predicts ack/done events from a
// transaction-level model, a negedge monitor pops and compares them.
module tb_beep_sched;
    localparam int ON  = 4;
    localparam int OFF = 3;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  tone_in;
    logic [15:0] count_in;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        busy;
    logic        beep_en;
    logic [1:0]  tone_sel;

    beep_sched #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .req     (req),
        .tone_in (tone_in),
        .count_in(count_in),
        .ack     (ack),
        .done    (done),
        .busy    (busy),
        .beep_en (beep_en),
        .tone_sel(tone_sel)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int idx;
        int cyc;
        int tone;
        int highs;
        int beep_at_ack;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Requester model: held requests and their data fields.
    logic [3:0] pend;
    logic [1:0] m_tone [4];
    logic [3:0] m_cnt  [4];
    int         ptr;

    task automatic chk(input string name, input int act, input int req_v);
        total++;
        if (act != req_v) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic drive_bus();
        req = pend;
        for (int i = 0; i < 4; i++) begin
            tone_in[2*i +: 2]  = m_tone[i];
            count_in[4*i +: 4] = m_cnt[i];
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < 4; k++) begin
`ifdef BEEP_SCHED_RR_EN
            int i = (ptr + k) % 4;
`else
            int i = k;
`endif
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    // Requesters not currently holding a request may change their fields freely;
    // occasionally a new requester raises req mid-burst.
    task automatic perturb();
        for (int i = 0; i < 4; i++) begin
            if (!pend[i]) begin
                m_tone[i] = 2'($urandom_range(0, 3));
                m_cnt[i]  = 4'($urandom_range(0, 15));
            end
        end
        if ($urandom_range(0, 5) == 0) begin
            int i = int'($urandom_range(0, 3));
            if (!pend[i]) begin
                pend[i]  = 1'b1;
                m_tone[i] = 2'($urandom_range(0, 3));
                m_cnt[i]  = 4'($urandom_range(0, 4));
            end
        end
    endtask

    // One grant: called at the negedge where req has just been driven with the
    // DUT in IDLE. Returns at the negedge of the done cycle (or after an abort).
    task automatic serve(input bit reraise, input bit rand_mode, input int abort_at);
        int w, n, t, d, ack_cyc;
        exp_t e;
        w = pick();
`ifdef BEEP_SCHED_RR_EN
        ptr = (w + 1) % 4;
`endif
        n = int'(m_cnt[w]);
        t = int'(m_tone[w]);
        d = (n == 0) ? 1 : n * (ON + OFF);
        ack_cyc = cyc + 1;
        e.is_done = 1'b0; e.idx = w; e.cyc = ack_cyc; e.tone = t; e.highs = 0; e.beep_at_ack = (n != 0) ? 1 : 0;
        sb.push_back(e);
        e.is_done = 1'b1; e.cyc = ack_cyc + d; e.highs = n * ON; e.beep_at_ack = 0;
        sb.push_back(e);

        @(negedge sys_clk);
        pend[w] = 1'b0;
        if (rand_mode) perturb();
        drive_bus();
        while (cyc < ack_cyc + d) begin
            @(negedge sys_clk);
            if (abort_at > 0 && cyc == ack_cyc + abort_at) begin
                rst  = 1'b1;
                sb.delete();
                pend = 4'd0;
                ptr  = 0;
                drive_bus();
                @(negedge sys_clk);
                chk("abort_ack", int'(ack), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_beep_en", int'(beep_en), 0);
                chk("abort_tone_sel", int'(tone_sel), 0);
                rst = 1'b0;
                return;
            end
            if (rand_mode) perturb();
            drive_bus();
        end
        if (reraise) begin
            pend[w] = 1'b1;
            drive_bus();
        end
    endtask

    // Monitor: pops one expectation per ack/done pulse and checks side outputs.
    int highs    = 0;
    int cur_tone = 0;
    always @(negedge sys_clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_%s: no pulse for idx %0d, required at cycle %0d (now %0d)",
                         sb[0].is_done ? "done" : "ack", sb[0].idx, sb[0].cyc, cyc);
                mon_e = sb.pop_front();
            end
            chk("ack_done_exclusive", int'((ack != 4'd0) && (done != 4'd0)), 0);
            if (ack != 4'd0) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got %b required none (cycle %0d)", ack, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_vec", int'(ack), 1 << mon_e.idx);
                    chk("ack_cycle", cyc, mon_e.cyc);
                    chk("ack_tone", int'(tone_sel), mon_e.tone);
                    chk("ack_busy", int'(busy), 1);
                    chk("ack_beep_en", int'(beep_en), mon_e.beep_at_ack);
                    cur_tone = mon_e.tone;
                end
                highs = beep_en ? 1 : 0;
            end else if (beep_en) begin
                highs++;
            end
            if (done != 4'd0) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got %b required none (cycle %0d)", done, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_vec", int'(done), 1 << mon_e.idx);
                    chk("done_cycle", cyc, mon_e.cyc);
                    chk("done_busy", int'(busy), 0);
                    chk("done_beep_en", int'(beep_en), 0);
                    chk("beep_high_cycles", highs, mon_e.highs);
                end
            end
            if (busy && ack == 4'd0) chk("tone_hold", int'(tone_sel), cur_tone);
        end
    end

    initial begin
        rst      = 1'b1;
        pend     = 4'd0;
        ptr      = 0;
        for (int i = 0; i < 4; i++) begin
            m_tone[i] = 2'd0;
            m_cnt[i]  = 4'd0;
        end
        drive_bus();
        repeat (3) @(negedge sys_clk);
        chk("rst_ack", int'(ack), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_beep_en", int'(beep_en), 0);
        chk("rst_tone_sel", int'(tone_sel), 0);
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("idle_busy", int'(busy), 0);

        // Single request: requester 1, tone 3, two beeps.
        m_tone[1] = 2'd3; m_cnt[1] = 4'd2; pend = 4'b0010; drive_bus();
        serve(1'b0, 1'b0, 0);
        @(negedge sys_clk);

        // Zero-count request.
        m_tone[2] = 2'd1; m_cnt[2] = 4'd0; pend = 4'b0100; drive_bus();
        serve(1'b0, 1'b0, 0);
        @(negedge sys_clk);

        // Full contention, winner re-raises after each done.
        for (int i = 0; i < 4; i++) begin
            m_tone[i] = 2'(i);
            m_cnt[i]  = 4'd1;
        end
        pend = 4'b1111; drive_bus();
        repeat (5) serve(1'b1, 1'b0, 0);
        while (pend != 4'd0) serve(1'b0, 1'b0, 0);
        @(negedge sys_clk);

        // Reset during the second beep, then a normal request.
        m_tone[1] = 2'd2; m_cnt[1] = 4'd3; pend = 4'b0010; drive_bus();
        serve(1'b0, 1'b0, ON + OFF + 1);
        repeat (2) @(negedge sys_clk);
        m_tone[0] = 2'd1; m_cnt[0] = 4'd1; pend = 4'b0001; drive_bus();
        serve(1'b0, 1'b0, 0);

        // Randomized traffic with mid-burst req/data churn and back-to-back grants.
        for (int it = 0; it < 40; it++) begin
            if (pend == 4'd0) begin
                repeat ($urandom_range(0, 3)) @(negedge sys_clk);
                pend = 4'($urandom_range(1, 15));
                for (int i = 0; i < 4; i++) begin
                    m_tone[i] = 2'($urandom_range(0, 3));
                    m_cnt[i]  = 4'($urandom_range(0, 4));
                end
                drive_bus();
            end
            serve(1'b0, 1'b1, 0);
        end
        while (pend != 4'd0) serve(1'b0, 1'b0, 0);

        repeat (4) @(negedge sys_clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
